// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width, operation codes and the
// divider FSM state type.
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [5:0] MULTU = 6'd25;
  localparam logic [5:0] DIVU  = 6'd27;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, dq} left by one, trial-subtract
// the divisor from the widened remainder and keep the result if no borrow.
// The freed low bit of dq receives the new quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] dq_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] dq_out
);

  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH+1:0] diff_s;
  logic             borrow_s;

  // Shift, trial subtract, and select the restored or reduced remainder.
  always_comb begin
    rem_sh_s = {rem_in, dq_in[WIDTH-1]};
    diff_s   = {1'b0, rem_sh_s} - {2'b00, divisor};
    borrow_s = diff_s[WIDTH+1];
    if (borrow_s) begin
      rem_out = rem_sh_s[WIDTH-1:0];
    end else begin
      rem_out = diff_s[WIDTH-1:0];
    end
    dq_out = {dq_in[WIDTH-2:0], ~borrow_s};
  end

endmodule

// File: rtl/divider.sv
// Multi-cycle unsigned divider: one quotient bit per clock using a
// restoring algorithm. Divide-by-zero completes in a single cycle with an
// all-ones quotient, the dividend as remainder and the dbz flag set.
module divider #(
  parameter int         WIDTH = alu_pkg::WIDTH,
  parameter logic [5:0] DIVU  = alu_pkg::DIVU
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       ctl,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  import alu_pkg::*;

  localparam int CW = $clog2(WIDTH);

  state_t           state_r, state_s;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dq_r;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             dbz_r;

  logic [WIDTH-1:0] rem_next_s;
  logic [WIDTH-1:0] dq_next_s;
  logic             accept_s;
  logic             b_zero_s;
  logic             last_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .dq_in   (dq_r),
    .divisor (divisor_r),
    .rem_out (rem_next_s),
    .dq_out  (dq_next_s)
  );

  // A new request is taken only when no division is in flight.
  always_comb begin
    accept_s = start && (ctl == DIVU) &&
               ((state_r == ST_IDLE) || (state_r == ST_DONE));
    b_zero_s = (b == '0);
    last_s   = (state_r == ST_RUN) && (count_r == CW'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; DONE lasts one cycle unless a new request chains in.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = b_zero_s ? ST_DONE : ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (accept_s) begin
          state_s = b_zero_s ? ST_DONE : ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Operand capture, iteration and result loading on entry to DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r     <= '0;
      rem_r       <= '0;
      dq_r        <= '0;
      divisor_r   <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
    end else if (accept_s) begin
      count_r   <= '0;
      rem_r     <= '0;
      dq_r      <= a;
      divisor_r <= b;
      if (b_zero_s) begin
        quotient_r  <= '1;
        remainder_r <= a;
        dbz_r       <= 1'b1;
      end
    end else if (state_r == ST_RUN) begin
      rem_r <= rem_next_s;
      dq_r  <= dq_next_s;
      if (last_s) begin
        quotient_r  <= dq_next_s;
        remainder_r <= rem_next_s;
        dbz_r       <= 1'b0;
      end else begin
        count_r <= count_r + CW'(1);
      end
    end
  end

  assign busy      = (state_r == ST_RUN);
  assign done      = (state_r == ST_DONE);
  assign quotient  = quotient_r;
  assign remainder = remainder_r;
  assign dbz       = dbz_r;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed cases plus randomized operands
// compared against plain-arithmetic division.
module tb_divider;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic [5:0]  ctl;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        dbz;

  int errors = 0;
  int checks = 0;

  divider #(.WIDTH(32), .DIVU(DIVU)) dut (
    .clk       (clk),
    .rst       (rst),
    .ctl       (ctl),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one division from the current negedge and wait for its done.
  // With hold set, start stays high with other operands during RUN.
  task automatic do_div(input logic [31:0] da, input logic [31:0] db, input bit hold);
    logic [31:0] eq, er;
    logic        edbz;
    int          lat, bcnt;
    bit          seen, both;
    if (db == 32'd0) begin
      eq = 32'hFFFF_FFFF; er = da; edbz = 1'b1;
    end else begin
      eq = da / db; er = da % db; edbz = 1'b0;
    end
    ctl = DIVU; start = 1'b1; a = da; b = db;
    @(posedge clk);
    lat = 0; bcnt = 0; seen = 1'b0; both = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (hold && lat < 20) begin
        start = 1'b1; a = 32'd9; b = 32'd2;
      end else begin
        start = 1'b0;
      end
      if (busy && done) both = 1'b1;
      if (busy) bcnt++;
      if (done) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'd1);
    check("latency", 64'(lat), (db == 32'd0) ? 64'd1 : 64'd33);
    check("busy_cycles", 64'(bcnt), (db == 32'd0) ? 64'd0 : 64'd32);
    check("busy_and_done", 64'(both), 64'd0);
    check("quotient", 64'(quotient), 64'(eq));
    check("remainder", 64'(remainder), 64'(er));
    check("dbz", 64'(dbz), 64'(edbz));
  endtask

  // After a done with no follow-up request: pulse ends, results hold.
  task automatic after_done(input logic [31:0] eq, input logic [31:0] er);
    @(negedge clk);
    check("done_pulse_end", 64'(done), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("q_held", 64'(quotient), 64'(eq));
    check("r_held", 64'(remainder), 64'(er));
  endtask

  initial begin
    logic [31:0] ra, rb;
    int sel;
    rst = 1'b0; ctl = 6'd0; start = 1'b0; a = 32'd0; b = 32'd0;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_q", 64'(quotient), 64'd0);
    check("rst_r", 64'(remainder), 64'd0);
    check("rst_dbz", 64'(dbz), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Basic case, first accept right after reset release.
    do_div(32'd100, 32'd7, 1'b0);
    after_done(32'd14, 32'd2);

    do_div(32'hFFFF_FFFF, 32'd1, 1'b0);
    do_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    after_done(32'd1, 32'd0);

    do_div(32'd5, 32'd0, 1'b0);
    after_done(32'hFFFF_FFFF, 32'd5);

    // a < b, with a competing request held during RUN.
    do_div(32'd3, 32'd10, 1'b1);
    after_done(32'd0, 32'd3);

    // Non-divide op code is ignored.
    ctl = MULTU; start = 1'b1; a = 32'd77; b = 32'd7;
    repeat (3) @(negedge clk);
    check("ign_busy", 64'(busy), 64'd0);
    check("ign_done", 64'(done), 64'd0);
    check("ign_q", 64'(quotient), 64'd0);
    check("ign_r", 64'(remainder), 64'd3);
    start = 1'b0;

    // Reset in the middle of RUN aborts without a done.
    do_div(32'd100, 32'd7, 1'b0);
    ctl = DIVU; start = 1'b1; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("run_busy_pre_rst", 64'(busy), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_q", 64'(quotient), 64'd0);
    check("abort_r", 64'(remainder), 64'd0);
    check("abort_dbz", 64'(dbz), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (done) check("no_done_after_abort", 64'(done), 64'd0);
    end
    do_div(32'd1000, 32'd3, 1'b0);

    // Back-to-back: next request issued during the DONE cycle.
    do_div(32'd50, 32'd5, 1'b0);
    after_done(32'd10, 32'd0);

    // Randomized operands, including zero divisors and small values.
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 4));
      ra = $urandom;
      rb = $urandom;
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) rb = rb & 32'h0000_00FF;
      else if (sel == 2) ra = ra & 32'h0000_FFFF;
      do_div(ra, rb, ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
